// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode values, strobe bit
// positions and controller state encoding.
// Ports: none (package).
package alu_pkg;

   // 5-bit opcodes as issued by the control unit
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   // Bit positions inside the one-hot ALU strobe vector
   localparam int ADD_B  = 0;
   localparam int SUB_B  = 1;
   localparam int MUL_B  = 2;
   localparam int DIV_B  = 3;
   localparam int AND_B  = 4;
   localparam int OR_B   = 5;
   localparam int SHR_B  = 6;
   localparam int SHRA_B = 7;
   localparam int SHL_B  = 8;
   localparam int ROR_B  = 9;
   localparam int ROL_B  = 10;
   localparam int NEG_B  = 11;
   localparam int NOT_B  = 12;
   localparam int NUM_OPS = 13;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Purpose: map a 5-bit opcode onto the one-hot ALU strobe vector.
// Latency: purely combinational. Backpressure: none.
// Ports: opcode in; onehot (strobe pattern, all-zero if unknown),
//        is_muldiv (MUL or DIV), legal (opcode is in the table) out.
module alu_op_decoder
   import alu_pkg::*;
(
   input  logic [4:0]         opcode,
   output logic [NUM_OPS-1:0] onehot,
   output logic               is_muldiv,
   output logic               legal
);

   always_comb begin
      onehot = '0;
      case (opcode)
         OP_ADD:  onehot[ADD_B]  = 1'b1;
         OP_SUB:  onehot[SUB_B]  = 1'b1;
         OP_MUL:  onehot[MUL_B]  = 1'b1;
         OP_DIV:  onehot[DIV_B]  = 1'b1;
         OP_AND:  onehot[AND_B]  = 1'b1;
         OP_OR:   onehot[OR_B]   = 1'b1;
         OP_SHR:  onehot[SHR_B]  = 1'b1;
         OP_SHRA: onehot[SHRA_B] = 1'b1;
         OP_SHL:  onehot[SHL_B]  = 1'b1;
         OP_ROR:  onehot[ROR_B]  = 1'b1;
         OP_ROL:  onehot[ROL_B]  = 1'b1;
         OP_NEG:  onehot[NEG_B]  = 1'b1;
         OP_NOT:  onehot[NOT_B]  = 1'b1;
         default: onehot = '0;
      endcase
      // Any decoded strobe means the opcode was recognised
      legal     = |onehot;
      is_muldiv = onehot[MUL_B] | onehot[DIV_B];
   end

endmodule

// File: rtl/alu_sequencer.sv
// Purpose: issue one ALU operation at a time, hold its strobe for a settle
//          window, then capture Chigh/Clow into Z or HI/LO and pulse done.
// Latency: start -> strobe cycles 1..N -> done in cycle N+1; rejected ops done in cycle 1.
// Backpressure: start is ignored while busy; a start during the done cycle is accepted.
// Ports: clock/clear (sync, active-low); start/opcode/ra_val/rb_val request;
//        alu_a/alu_b/alu_op drive the ALU, alu_chigh/alu_clow return from it;
//        busy/done/illegal/div_zero status; z_out/hi_out/lo_out results.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int SETTLE_CYC = 1,
   parameter int MULDIV_CYC = 3
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 start,
   input  logic [4:0]           opcode,
   input  logic [31:0]          ra_val,
   input  logic [31:0]          rb_val,
   output logic [31:0]          alu_a,
   output logic [31:0]          alu_b,
   output logic [NUM_OPS-1:0]   alu_op,
   input  logic [31:0]          alu_chigh,
   input  logic [31:0]          alu_clow,
   output logic                 busy,
   output logic                 done,
   output logic                 illegal,
   output logic                 div_zero,
   output logic [31:0]          z_out,
   output logic [31:0]          hi_out,
   output logic [31:0]          lo_out
);

   // Counter holds N-1 at most; keep at least one bit when MULDIV_CYC is 1
   localparam int CW = (MULDIV_CYC > 1) ? $clog2(MULDIV_CYC) : 1;
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] MULDIV_LOAD = CW'(MULDIV_CYC - 1);

   state_t               state;
   logic [CW-1:0]        wait_cnt;
   logic [NUM_OPS-1:0]   dec_onehot;
   logic                 dec_muldiv;
   logic                 dec_legal;
   logic                 dec_div_zero;
   logic                 run_muldiv;

   alu_op_decoder u_dec (
      .opcode    (opcode),
      .onehot    (dec_onehot),
      .is_muldiv (dec_muldiv),
      .legal     (dec_legal)
   );

   // Rejected before the ALU ever sees it, so no strobe is raised for /0
   assign dec_div_zero = dec_onehot[DIV_B] && (rb_val == 32'd0);

   // The held strobe tells us which result registers the capture targets
   assign run_muldiv = alu_op[MUL_B] | alu_op[DIV_B];

   always_ff @(posedge clock) begin
      if (!clear) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         illegal  <= 1'b0;
         div_zero <= 1'b0;
         z_out    <= '0;
         hi_out   <= '0;
         lo_out   <= '0;
      end else begin
         // Status flags are single-cycle pulses unless re-armed below
         done     <= 1'b0;
         illegal  <= 1'b0;
         div_zero <= 1'b0;

         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  if (dec_legal && !dec_div_zero) begin
                     alu_a    <= ra_val;
                     alu_b    <= rb_val;
                     alu_op   <= dec_onehot;
                     wait_cnt <= dec_muldiv ? MULDIV_LOAD : SETTLE_LOAD;
                     busy     <= 1'b1;
                     state    <= ST_RUN;
                  end else begin
                     done     <= 1'b1;
                     illegal  <= !dec_legal;
                     div_zero <= dec_div_zero;
                     state    <= ST_DONE;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end

            ST_RUN: begin
               if (wait_cnt == '0) begin
                  if (run_muldiv) begin
                     hi_out <= alu_chigh;
                     lo_out <= alu_clow;
                  end else begin
                     z_out  <= alu_clow;
                  end
                  alu_op <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt - CW'(1);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Purpose: self-checking bench for alu_sequencer with a behavioural ALU model.
// Latency: n/a. Backpressure: n/a.
// Ports: none.
module tb_alu_sequencer;

   localparam int SETTLE = 1;
   localparam int MULDIV = 3;
   localparam int LAT_S  = SETTLE + 1;
   localparam int LAT_M  = MULDIV + 1;

   logic        clock, clear, start;
   logic [4:0]  opcode;
   logic [31:0] ra_val, rb_val, alu_a, alu_b, alu_chigh, alu_clow;
   logic [12:0] alu_op;
   logic        busy, done, illegal, div_zero;
   logic [31:0] z_out, hi_out, lo_out;

   int total = 0;
   int bad   = 0;

   alu_sequencer #(.SETTLE_CYC(SETTLE), .MULDIV_CYC(MULDIV)) dut (
      .clock(clock), .clear(clear), .start(start), .opcode(opcode),
      .ra_val(ra_val), .rb_val(rb_val), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_chigh(alu_chigh), .alu_clow(alu_clow),
      .busy(busy), .done(done), .illegal(illegal), .div_zero(div_zero),
      .z_out(z_out), .hi_out(hi_out), .lo_out(lo_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Stand-in ALU: single-word ops put the result on Clow and its inverse on
   // Chigh so a wrong capture source is visible; idle output is a marker.
   logic [31:0] r;
   logic [63:0] mul_p, ror64, rol64;
   always_comb begin
      r         = 32'hDEAD_BEEF;
      alu_chigh = 32'hDEAD_BEEF;
      alu_clow  = 32'hDEAD_BEEF;
      mul_p = {{32{alu_a[31]}}, alu_a} * {{32{alu_b[31]}}, alu_b};
      ror64 = {alu_a, alu_a} >> alu_b[4:0];
      rol64 = {alu_a, alu_a} << alu_b[4:0];
      case (alu_op)
         13'h0001: r = alu_a + alu_b;
         13'h0002: r = alu_a - alu_b;
         13'h0010: r = alu_a & alu_b;
         13'h0020: r = alu_a | alu_b;
         13'h0040: r = alu_a >> alu_b[4:0];
         13'h0080: r = $signed(alu_a) >>> alu_b[4:0];
         13'h0100: r = alu_a << alu_b[4:0];
         13'h0200: r = ror64[31:0];
         13'h0400: r = rol64[63:32];
         13'h0800: r = 32'd0 - alu_a;
         13'h1000: r = ~alu_a;
         default:  r = 32'hDEAD_BEEF;
      endcase
      if (alu_op != 13'h0000 && alu_op != 13'h0004 && alu_op != 13'h0008) begin
         alu_clow  = r;
         alu_chigh = ~r;
      end else if (alu_op == 13'h0004) begin
         alu_chigh = mul_p[63:32];
         alu_clow  = mul_p[31:0];
      end else if (alu_op == 13'h0008 && alu_b != 32'd0) begin
         alu_clow  = $signed(alu_a) / $signed(alu_b);
         alu_chigh = $signed(alu_a) % $signed(alu_b);
      end
   end

   // Opcodes ordered by their strobe bit
   logic [4:0] legal_ops [13] = '{5'b00011, 5'b00100, 5'b01111, 5'b10000, 5'b01010,
                                  5'b01011, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                  5'b01001, 5'b10001, 5'b10010};

   function automatic logic [12:0] oh_of(input logic [4:0] op);
      logic [12:0] v;
      v = '0;
      for (int i = 0; i < 13; i++)
         if (legal_ops[i] == op) v[i] = 1'b1;
      return v;
   endfunction

   // Reference result: {hi,lo} for MUL/DIV, {0,z} otherwise
   function automatic logic [63:0] ref_calc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int          sa, sb;
      int unsigned s;
      longint      p;
      sa = int'(a);
      sb = int'(b);
      s  = int'(b[4:0]);
      case (op)
         5'b00011: return {32'd0, a + b};
         5'b00100: return {32'd0, a - b};
         5'b01111: begin p = longint'(sa) * longint'(sb); return 64'(p); end
         5'b10000: return {32'(sa % sb), 32'(sa / sb)};
         5'b01010: return {32'd0, a & b};
         5'b01011: return {32'd0, a | b};
         5'b00101: return {32'd0, a >> s};
         5'b00110: return {32'd0, 32'(sa >>> s)};
         5'b00111: return {32'd0, a << s};
         5'b01000: return {32'd0, (a >> s) | (a << ((32 - s) % 32))};
         5'b01001: return {32'd0, (a << s) | (a >> ((32 - s) % 32))};
         5'b10001: return {32'd0, 32'(-sa)};
         5'b10010: return {32'd0, ~a};
         default:  return 64'd0;
      endcase
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Issue one request and follow it to its done pulse
   task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ez, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic eill, input logic edz, input int elat);
      int strobes = 0, wrong = 0, done_cyc = -1;
      logic [12:0] eoh;
      eoh = (elat > 1) ? oh_of(op) : 13'h0;
      @(negedge clock);
      start = 1'b1; opcode = op; ra_val = a; rb_val = b;
      @(negedge clock);
      start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (done) begin done_cyc = c; break; end
         if (alu_op == eoh && busy && alu_a == a && alu_b == b) strobes++;
         else wrong++;
         @(negedge clock);
      end
      check({nm, ".done_cycle"}, 64'(done_cyc), 64'(elat));
      check({nm, ".strobe_cycles"}, 64'(strobes), 64'(elat - 1));
      check({nm, ".bad_cycles"}, 64'(wrong), 64'd0);
      check({nm, ".flags"}, {busy, alu_op, illegal, div_zero}, {1'b0, 13'h0, eill, edz});
      check({nm, ".z"}, 64'(z_out), 64'(ez));
      check({nm, ".hilo"}, {hi_out, lo_out}, {ehi, elo});
      @(negedge clock);
      check({nm, ".after"}, {done, illegal, div_zero, alu_op}, 16'h0);
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a, b, z, hi, lo;
      logic        ill, dz;
      int          lat;
   } vec_t;

   vec_t vt [15];
   logic [31:0] mz, mhi, mlo;

   initial begin
      vt[0]  = '{5'b00011, 32'd5, 32'd7, 32'h0000000C, 32'd0, 32'd0, 1'b0, 1'b0, LAT_S};
      vt[1]  = '{5'b01111, 32'hFFFFFFFD, 32'd4, 32'h0000000C, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0, 1'b0, LAT_M};
      vt[2]  = '{5'b10000, 32'd17, 32'd5, 32'h0000000C, 32'd2, 32'd3, 1'b0, 1'b0, LAT_M};
      vt[3]  = '{5'b10000, 32'd17, 32'd0, 32'h0000000C, 32'd2, 32'd3, 1'b0, 1'b1, 1};
      vt[4]  = '{5'b00000, 32'd1, 32'd2, 32'h0000000C, 32'd2, 32'd3, 1'b1, 1'b0, 1};
      vt[5]  = '{5'b01000, 32'd1, 32'd1, 32'h80000000, 32'd2, 32'd3, 1'b0, 1'b0, LAT_S};
      vt[6]  = '{5'b00110, 32'h80000000, 32'd4, 32'hF8000000, 32'd2, 32'd3, 1'b0, 1'b0, LAT_S};
      vt[7]  = '{5'b00111, 32'd3, 32'd2, 32'h0000000C, 32'd2, 32'd3, 1'b0, 1'b0, LAT_S};
      vt[8]  = '{5'b10010, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd2, 32'd3, 1'b0, 1'b0, LAT_S};
      vt[9]  = '{5'b10001, 32'd5, 32'd0, 32'hFFFFFFFB, 32'd2, 32'd3, 1'b0, 1'b0, LAT_S};
      vt[10] = '{5'b01010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'd2, 32'd3, 1'b0, 1'b0, LAT_S};
      vt[11] = '{5'b11111, 32'd9, 32'd9, 32'h00F000F0, 32'd2, 32'd3, 1'b1, 1'b0, 1};
      vt[12] = '{5'b00101, 32'h80000000, 32'd31, 32'h00000001, 32'd2, 32'd3, 1'b0, 1'b0, LAT_S};
      vt[13] = '{5'b01001, 32'h80000001, 32'd4, 32'h00000018, 32'd2, 32'd3, 1'b0, 1'b0, LAT_S};
      vt[14] = '{5'b01011, 32'h00001200, 32'h00000034, 32'h00001234, 32'd2, 32'd3, 1'b0, 1'b0, LAT_S};

      start = 1'b0; opcode = '0; ra_val = '0; rb_val = '0; clear = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_outputs", {alu_a, alu_b, alu_op, busy, done, illegal, div_zero},
            {64'd0, 13'h0, 4'h0});
      check("reset_results", {z_out, hi_out}, 64'd0);
      check("reset_lo", 64'(lo_out), 64'd0);
      clear = 1'b1;

      for (int i = 0; i < 15; i++)
         run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].z, vt[i].hi,
                vt[i].lo, vt[i].ill, vt[i].dz, vt[i].lat);

      // Randomised operations checked against the reference model
      mz = 32'h00001234; mhi = 32'd2; mlo = 32'd3;
      for (int n = 0; n < 40; n++) begin
         int k;
         logic [4:0] op;
         logic [31:0] a, b;
         logic ill, dz;
         logic [63:0] res;
         int lat;
         k = int'($urandom_range(0, 14));
         a = $urandom; b = $urandom;
         ill = 1'b0; dz = 1'b0;
         if (k < 13) op = legal_ops[k];
         else if (k == 13) op = 5'($urandom_range(19, 31));
         else begin op = 5'b10000; b = 32'd0; end
         if (k == 3) b = $urandom_range(1, 1000);
         if (k == 13) begin ill = 1'b1; lat = 1; end
         else if (k == 14) begin dz = 1'b1; lat = 1; end
         else if (k == 2 || k == 3) begin
            res = ref_calc(op, a, b); mhi = res[63:32]; mlo = res[31:0]; lat = LAT_M;
         end else begin
            res = ref_calc(op, a, b); mz = res[31:0]; lat = LAT_S;
         end
         run_op($sformatf("rnd%0d", n), op, a, b, mz, mhi, mlo, ill, dz, lat);
      end

      // A start during RUN of MUL is neither queued nor flagged
      @(negedge clock);
      start = 1'b1; opcode = 5'b01111; ra_val = 32'd7; rb_val = 32'd6;
      @(negedge clock); start = 1'b0;
      @(negedge clock); start = 1'b1; opcode = 5'b00011; ra_val = 32'd1; rb_val = 32'd1;
      @(negedge clock); start = 1'b0;
      check("ignore.still_mul", {alu_op, alu_a}, {13'h0004, 32'd7});
      @(negedge clock);
      check("ignore.done", {done, hi_out, lo_out}, {1'b1, 32'd0, 32'd42});
      @(negedge clock);
      check("ignore.idle1", {alu_op, busy, done}, 15'h0);
      @(negedge clock);
      check("ignore.idle2", {alu_op, busy, z_out}, {13'h0, 1'b0, mz});

      // start held through the DONE cycle of SUB issues the next op at once
      @(negedge clock);
      start = 1'b1; opcode = 5'b00100; ra_val = 32'd9; rb_val = 32'd4;
      @(negedge clock);
      opcode = 5'b00011; ra_val = 32'd1; rb_val = 32'd2;
      @(negedge clock);
      check("b2b.sub_done", {done, z_out}, {1'b1, 32'd5});
      @(negedge clock);
      start = 1'b0;
      check("b2b.add_strobe", {alu_op, busy, done}, {13'h0001, 1'b1, 1'b0});
      @(negedge clock);
      check("b2b.add_done", {done, z_out}, {1'b1, 32'd3});

      // Reset in cycle 2 of a MUL kills it without a done pulse
      @(negedge clock);
      start = 1'b1; opcode = 5'b01111; ra_val = 32'hFFFFFFFD; rb_val = 32'd4;
      @(negedge clock); start = 1'b0;
      check("rst.mul_strobe", 64'(alu_op), 64'h0004);
      @(negedge clock); clear = 1'b0;
      @(negedge clock); clear = 1'b1;
      check("rst.cleared", {alu_op, busy, done, alu_a}, {13'h0, 2'b00, 32'd0});
      check("rst.results", {z_out, hi_out}, 64'd0);
      check("rst.lo", 64'(lo_out), 64'd0);
      begin
         int dones = 0;
         repeat (6) begin
            @(negedge clock);
            if (done) dones++;
         end
         check("rst.no_done", 64'(dones), 64'd0);
      end
      run_op("rst.add", 5'b00011, 32'd5, 32'd7, 32'h0000000C, 32'd0, 32'd0, 1'b0, 1'b0, LAT_S);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Registered controller that sequences the Phase 3 ALU for one operation at a time. It accepts an opcode plus two operands on a start pulse, latches the operands onto the ALU inputs, and holds one one-hot ALU strobe for a fixed settle window (longer for MUL/DIV). It then captures Chigh/Clow into the Z or HI/LO result registers and pulses done. The block sits between the control unit and the ALU. It rejects illegal opcodes and divide-by-zero before the ALU is ever strobed.

Parameters:
SETTLE_CYC, 1, cycles the strobe is held for single-cycle ops (ADD..NOT except MUL/DIV); must be >=1
MULDIV_CYC, 3, cycles the strobe is held for MUL and DIV; must be >=SETTLE_CYC

Ports:
clock  in  1  system clock, rising edge
clear  in  1  synchronous reset, active low
start  in  1  request pulse; sampled only when busy=0
opcode  in  5  ADD 00011, SUB 00100, MUL 01111, DIV 10000, AND 01010, OR 01011, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, NEG 10001, NOT 10010
ra_val  in  32  operand A
rb_val  in  32  operand B
alu_a  out  32  registered operand A to ALU
alu_b  out  32  registered operand B to ALU
alu_op  out  13  one-hot ALU strobes, bit0..12 = ADD,SUB,MUL,DIV,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT
alu_chigh  in  32  ALU Chigh
alu_clow  in  32  ALU Clow
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
illegal  out  1  one-cycle pulse with done: opcode not in table
div_zero  out  1  one-cycle pulse with done: DIV with rb_val==0
z_out  out  32  result of non-MUL/DIV ops
hi_out  out  32  MUL high word / DIV remainder
lo_out  out  32  MUL low word / DIV quotient

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-low (clear=0 at a rising edge).
- Reset values: all outputs are 0 and state is IDLE. A reset mid-operation drops the strobe at that edge; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1, legal opcode, not DIV-by-zero:
  - At that edge, latch ra_val→alu_a, rb_val→alu_b.
  - Set the decoded alu_op bit and load the wait counter with N-1 (N=MULDIV_CYC for MUL/DIV, else SETTLE_CYC).
  - Set busy=1 and go to RUN.
- IDLE, start=1, illegal opcode or (DIV and rb_val==0):
  - Go to DONE with illegal or div_zero set.
  - alu_op stays 0; z/hi/lo are unchanged.
- RUN:
  - alu_op and alu_a/alu_b are held constant.
  - The counter decrements each cycle.
  - At the edge where the counter is 0: capture the result, clear alu_op, go to DONE.
  - MUL/DIV: hi_out←alu_chigh, lo_out←alu_clow; z_out unchanged.
  - All other ops: z_out←alu_clow; hi/lo unchanged.
- DONE:
  - done=1 for exactly one cycle; busy=0; results are valid from this cycle onward.
  - A start in DONE is accepted exactly as in IDLE (back-to-back issue).
  - With no start, go to IDLE.
- Latency:
  - start sampled at edge of cycle 0 → strobe high in cycles 1..N → done in cycle N+1.
  - Rejected requests → done in cycle 1.
- start while busy (RUN) is ignored; it is neither queued nor flagged.
- Between operations alu_op=0 and alu_a/alu_b keep their last values, so the ALU holds its result.
- illegal and div_zero are 0 whenever done=0.
- Wait counter width is $clog2(MULDIV_CYC); no wrap is possible because it is reloaded on each issue.
- No combinational path from inputs to outputs; every output is a flop.

Decomposition:
- Shared package alu_pkg:
  - 5-bit opcode localparams.
  - alu_op bit-index localparams (ADD_B=0 .. NOT_B=12).
  - State encoding IDLE/RUN/DONE.
- Sub-module alu_op_decoder (combinational):
  - Input: opcode.
  - Outputs: onehot[12:0], is_muldiv, legal.
- alu_sequencer instantiates alu_op_decoder and the real ALU only in the testbench.

Test Plan:
- ADD: opcode 00011, ra=5, rb=7, start at cycle 0 (defaults) → alu_op=0x0001 in cycle 1 only; done and z_out=0x0000000C in cycle 2; hi/lo unchanged.
- MUL: ra=0xFFFFFFFD, rb=4 → alu_op bit2 high cycles 1..3; done in cycle 4; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF4; z_out unchanged.
- DIV 17/5 → done in cycle 4, lo_out=3, hi_out=2. Then DIV 17/0 → done+div_zero in cycle 1, alu_op never asserted, hi/lo still 2/3.
- Opcode 00000 → done+illegal in cycle 1, busy never 1, all results unchanged. Then ROR ra=0x00000001, rb=1 → z_out=0x80000000.
- Handshake: second start during RUN of MUL is ignored. start held high through the DONE cycle of SUB 9-4 → z_out=5, next op issued that cycle, and its strobe rises the following cycle.
- Reset: clear=0 in cycle 2 of a MUL → at that edge alu_op=0, busy=0, hi/lo/z=0; no done ever pulses; a fresh ADD afterwards completes normally.
